// File: rtl/response_checker_pkg.sv
// Shared types and defaults for the response checker.
// The run FSM encoding, the MISR defaults and the response layout
// {count, result} live here so that the top and its users agree on them.
package response_checker_pkg;

  localparam int          RESP_COUNT_W  = 6;
  localparam logic [31:0] MISR_POLY_DEF = 32'h04C11DB7;
  localparam logic [31:0] MISR_SEED_DEF = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Packed order is the order used for comparison and MISR compaction.
  typedef struct packed {
    logic [RESP_COUNT_W-1:0] count;
    logic                    result;
  } resp_t;

endpackage

// File: rtl/response_checker_sync_fifo.sv
// Synchronous FIFO holding expected responses.
// Pointers carry one extra wrap bit so that full and empty both come
// straight from the registered pointers. Flush wins over push and pop.
module sync_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A push while full is refused even if a pop happens in the same cycle.
  assign push_ok = push_i && !full_o && !flush_i;
  assign pop_ok  = pop_i && !empty_o && !flush_i;

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer values; flush returns both to zero.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; occupancy is defined solely by the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/response_checker.sv
// End-of-path response checker.
// Expected responses are queued and compared in order against observed
// responses; mismatches are counted, the first failing index is kept and
// every observation is folded into a MISR signature.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | after reset, waiting for start; all traffic ignored
// ST_RUN  | accepting expected pushes and comparing observations
// ST_DONE | num_samples observed; results held until start or reset
module response_checker
  import response_checker_pkg::*;
#(
  parameter int                COUNT_W   = RESP_COUNT_W,
  parameter int                DEPTH     = 8,
  parameter int                IDX_W     = 16,
  parameter int                MISR_W    = 32,
  parameter logic [MISR_W-1:0] MISR_POLY = MISR_POLY_DEF,
  parameter logic [MISR_W-1:0] MISR_SEED = MISR_SEED_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [IDX_W-1:0]   num_samples,
  input  logic               exp_valid,
  output logic               exp_ready,
  input  logic [COUNT_W-1:0] exp_count,
  input  logic               exp_result,
  input  logic               obs_valid,
  input  logic [COUNT_W-1:0] obs_count,
  input  logic               obs_result,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [IDX_W-1:0]   mismatch_cnt,
  output logic               first_err_valid,
  output logic [IDX_W-1:0]   first_err_idx,
  output logic               underrun,
  output logic               leftover,
  output logic [MISR_W-1:0]  signature
);

  localparam int RESP_W = COUNT_W + 1;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   num_q;
  logic [IDX_W-1:0]   sample_idx_q;
  logic [IDX_W-1:0]   mismatch_cnt_q;
  logic               first_err_valid_q;
  logic [IDX_W-1:0]   first_err_idx_q;
  logic               underrun_q;
  logic [MISR_W-1:0]  sig_q;

  logic               in_run;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [RESP_W-1:0]  fifo_head;
  logic [RESP_W-1:0]  exp_word;
  logic [RESP_W-1:0]  obs_word;
  logic               obs_take;
  logic               is_mismatch;
  logic               last_obs;

  // One MISR step: shift left, fold back on the outgoing MSB, xor the data.
  function automatic logic [MISR_W-1:0] misr_next(input logic [MISR_W-1:0] s,
                                                  input logic [RESP_W-1:0] d);
    logic [MISR_W-1:0] fb;
    fb = s[MISR_W-1] ? MISR_POLY : '0;
    return {s[MISR_W-2:0], 1'b0} ^ fb ^ MISR_W'(d);
  endfunction

  assign exp_word = {exp_count, exp_result};
  assign obs_word = {obs_count, obs_result};

  // start pre-empts everything else in its cycle, so traffic is masked by it.
  assign in_run      = (state_q == ST_RUN);
  assign fifo_push   = in_run && !start && exp_valid && !fifo_full;
  assign obs_take    = in_run && !start && obs_valid;
  // An empty FIFO is an underrun even if a push lands this cycle: no bypass.
  assign fifo_pop    = obs_take && !fifo_empty;
  assign is_mismatch = obs_take && (fifo_empty || (obs_word != fifo_head));
  assign last_obs    = obs_take && (sample_idx_q == (num_q - IDX_W'(1)));

  sync_fifo #(
    .WIDTH (RESP_W),
    .DEPTH (DEPTH)
  ) u_exp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (start),
    .push_i  (fifo_push),
    .wdata_i (exp_word),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Run sequencing: start restarts from any state, last sample ends the run.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = (num_samples == '0) ? ST_DONE : ST_RUN;
    end else if (last_obs) begin
      state_d = ST_DONE;
    end
  end

  // State, run length and sample index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      num_q        <= '0;
      sample_idx_q <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        num_q        <= num_samples;
        sample_idx_q <= '0;
      end else if (obs_take) begin
        sample_idx_q <= sample_idx_q + IDX_W'(1);
      end
    end
  end

  // Error bookkeeping: saturating mismatch count, first failure, underrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_cnt_q    <= '0;
      first_err_valid_q <= 1'b0;
      first_err_idx_q   <= '0;
      underrun_q        <= 1'b0;
    end else if (start) begin
      mismatch_cnt_q    <= '0;
      first_err_valid_q <= 1'b0;
      first_err_idx_q   <= '0;
      underrun_q        <= 1'b0;
    end else if (obs_take) begin
      if (fifo_empty) underrun_q <= 1'b1;
      if (is_mismatch) begin
        if (mismatch_cnt_q != '1) mismatch_cnt_q <= mismatch_cnt_q + IDX_W'(1);
        if (!first_err_valid_q) begin
          first_err_valid_q <= 1'b1;
          first_err_idx_q   <= sample_idx_q;
        end
      end
    end
  end

  // Signature compaction of every observed sample during a run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= MISR_SEED;
    end else if (start) begin
      sig_q <= MISR_SEED;
    end else if (obs_take) begin
      sig_q <= misr_next(sig_q, obs_word);
    end
  end

  // Outputs are decodes of registered state only.
  assign exp_ready       = in_run && !fifo_full;
  assign busy            = in_run;
  assign done            = (state_q == ST_DONE);
  assign leftover        = done && !fifo_empty;
  assign pass            = done && (mismatch_cnt_q == '0) && !underrun_q && !leftover;
  assign mismatch_cnt    = mismatch_cnt_q;
  assign first_err_valid = first_err_valid_q;
  assign first_err_idx   = first_err_idx_q;
  assign underrun        = underrun_q;
  assign signature       = sig_q;

endmodule
